timer_alarm_sched: RTL and testbench

- J1-mapped alarm scheduler built around a free-running prescaled tick counter.
- Arms up to 4 compare channels, each one-shot or periodic.
- A service FSM sequences matched channels: sets pending flags and reloads periodic targets.
- Raises one interrupt line to the CPU. Sits beside the cycle timer on the peripheral bus; same addr/cs/rd/wr decode style.

---
 rtl/timer_alarm_sched.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_timer_alarm_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_alarm_sched.sv
// ---------------------------------------------------------------------------
// timer_alarm_sched
//
// Alarm scheduler for the J1 peripheral bus. A free-running 16-bit tick
// counter (COUNT) advances once every PRESC clock cycles while RUN is set.
// Four compare channels can be armed as one-shot or periodic alarms. A
// channel whose target equals the freshly incremented COUNT raises an
// internal hit. A small service FSM then walks the channels in order,
// turning each hit into a pending bit and either reloading a periodic
// target or disarming a one-shot channel. Any unmasked pending bit drives
// the level interrupt.
//
// Register map (16-bit, addr[3:0]):
//   0x0 COUNT   R, any write clears COUNT
//   0x1 CTRL    R/W [3:0] EN, [7:4] PER, [8] RUN
//   0x2 STATUS  R [3:0] pending, write-1-to-clear
//   0x3 IRQMASK R/W [3:0] (only with TIMER_ALARM_IRQ_MASK_EN), reset 0xF
//   0x4..0x7 CMP[0..3] R/W delay/period in ticks
//
// Optional feature macro: TIMER_ALARM_IRQ_MASK_EN
//   defined   -> IRQMASK register present, irq = |(pending & IRQMASK)
//   undefined -> 0x3 reads 0 and ignores writes, irq = |pending
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-low reset
//   addr      in   4  register address
//   cs        in   1  chip select
//   rd        in   1  read strobe (qualified by cs)
//   wr        in   1  write strobe (qualified by cs)
//   d_in      in  16  write data
//   data_out  out 16  registered read data, 0 when not reading
//   irq       out  1  registered level interrupt
//
// Parameters:
//   PRESC  clock cycles per tick, 5..255 (keeps the service pass shorter
//          than one tick period)
//   NCH    number of compare channels, fixed at 4 by the register map
// ---------------------------------------------------------------------------
module timer_alarm_sched #(
  parameter int PRESC = 8,
  parameter int NCH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] d_in,
  output logic [15:0] data_out,
  output logic        irq
);

  // Elaboration-time guard: the service pass needs at least 5 cycles per
  // tick, and the register map only has room for four channels.
  if (PRESC < 5 || PRESC > 255) begin : g_bad_presc
    $error("timer_alarm_sched: PRESC must be in 5..255");
  end
  if (NCH != 4) begin : g_bad_nch
    $error("timer_alarm_sched: NCH must be 4");
  end

  typedef enum logic {
    ST_IDLE,
    ST_SERV
  } state_t;

  // Timebase
  logic [7:0]  r_presc;
  logic [15:0] r_count;

  // Control and channel state
  logic        r_run;
  logic [3:0]  r_en;
  logic [3:0]  r_per;
  logic [3:0]  r_hit;
  logic [3:0]  r_pending;
  logic [15:0] r_cmp    [NCH];
  logic [15:0] r_target [NCH];

  // Service FSM
  state_t      r_state;
  logic [1:0]  r_ch;

  // Registered outputs
  logic [15:0] r_dataOut;
  logic        r_irq;

  // Decode and datapath wires
  logic        w_wrEn;
  logic        w_rdEn;
  logic        w_wrCount;
  logic        w_wrCtrl;
  logic        w_wrStatus;
  logic        w_wrCmp;
  logic        w_tick;
  logic [15:0] w_countInc;
  logic [3:0]  w_svcSet;
  logic [3:0]  w_enNext;
  logic [3:0]  w_arm;
  logic [3:0]  w_match;
  logic [3:0]  w_hitNext;
  logic [3:0]  w_pendingNext;
  logic [3:0]  w_w1c;
  logic [3:0]  w_mask;
  logic [15:0] w_rdData;

  assign w_wrEn     = cs & wr;
  assign w_rdEn     = cs & rd;
  assign w_wrCount  = w_wrEn & (addr == 4'h0);
  assign w_wrCtrl   = w_wrEn & (addr == 4'h1);
  assign w_wrStatus = w_wrEn & (addr == 4'h2);
  assign w_wrCmp    = w_wrEn & (addr[3:2] == 2'b01);

  // The tick fires on the last prescaler count, so COUNT and the compare
  // logic both see it on the same edge.
  assign w_tick     = r_run & (r_presc == 8'(PRESC - 1));
  assign w_countInc = r_count + 16'd1;

`ifdef TIMER_ALARM_IRQ_MASK_EN
  logic [3:0] r_mask;
  logic       w_wrMask;

  assign w_wrMask = w_wrEn & (addr == 4'h3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= 4'hF;
    end else if (w_wrMask) begin
      r_mask <= d_in[3:0];
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = 4'hF;
`endif

  // The channel currently addressed by the FSM is serviced only if its hit
  // survived until now; a hit dropped by disarming produces no pending bit.
  always_comb begin
    w_svcSet = 4'h0;
    if (r_state == ST_SERV && r_hit[r_ch]) begin
      w_svcSet[r_ch] = 1'b1;
    end
  end

  // Match uses the value COUNT is about to take. A coincident COUNT clear
  // wins over the tick, so no match is taken on that edge.
  always_comb begin
    w_match = 4'h0;
    for (int i = 0; i < NCH; i++) begin
      w_match[i] = w_tick & ~w_wrCount & r_en[i] & (w_countInc == r_target[i]);
    end
  end

  // A CPU CTRL write overrides the one-shot disarm done by the FSM. Arming
  // is judged against the enable bits as they stand before this edge.
  always_comb begin
    if (w_wrCtrl) begin
      w_enNext = d_in[3:0];
      w_arm    = d_in[3:0] & ~r_en;
    end else begin
      w_enNext = r_en & ~(w_svcSet & ~r_per);
      w_arm    = 4'h0;
    end
  end

  // Disabled channels lose any outstanding hit. FSM set beats W1C.
  assign w_hitNext     = ((r_hit & ~w_svcSet) | w_match) & w_enNext;
  assign w_w1c         = w_wrStatus ? d_in[3:0] : 4'h0;
  assign w_pendingNext = (r_pending & ~w_w1c) | w_svcSet;

  always_comb begin
    w_rdData = 16'h0;
    case (addr)
      4'h0: w_rdData = r_count;
      4'h1: w_rdData = {7'd0, r_run, r_per, r_en};
      4'h2: w_rdData = {12'd0, r_pending};
`ifdef TIMER_ALARM_IRQ_MASK_EN
      4'h3: w_rdData = {12'd0, r_mask};
`endif
      4'h4, 4'h5, 4'h6, 4'h7: w_rdData = r_cmp[addr[1:0]];
      default: w_rdData = 16'h0;
    endcase
  end

  // Prescaler and COUNT freeze together when RUN is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= 8'd0;
      r_count <= 16'd0;
    end else begin
      if (r_run) begin
        r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
      end
      if (w_wrCount) begin
        r_count <= 16'd0;
      end else if (w_tick) begin
        r_count <= w_countInc;
      end
    end
  end

  // Control, compare, target, hit and pending registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run     <= 1'b0;
      r_per     <= 4'h0;
      r_en      <= 4'h0;
      r_hit     <= 4'h0;
      r_pending <= 4'h0;
      for (int i = 0; i < NCH; i++) begin
        r_cmp[i]    <= 16'd0;
        r_target[i] <= 16'd0;
      end
    end else begin
      if (w_wrCtrl) begin
        r_run <= d_in[8];
        r_per <= d_in[7:4];
      end
      r_en      <= w_enNext;
      r_hit     <= w_hitNext;
      r_pending <= w_pendingNext;
      if (w_wrCmp) begin
        r_cmp[addr[1:0]] <= d_in;
      end
      // Changing CMP on an armed channel only affects the next reload.
      for (int i = 0; i < NCH; i++) begin
        if (w_arm[i]) begin
          r_target[i] <= r_count + r_cmp[i];
        end else if (w_svcSet[i] && r_per[i]) begin
          r_target[i] <= r_target[i] + r_cmp[i];
        end
      end
    end
  end

  // Service FSM: one pass over all four channels whenever any hit exists.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ch    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_hit) begin
            r_state <= ST_SERV;
            r_ch    <= 2'd0;
          end
        end
        ST_SERV: begin
          if (r_ch == 2'd3) begin
            r_state <= ST_IDLE;
          end
          r_ch <= r_ch + 2'd1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ch    <= 2'd0;
        end
      endcase
    end
  end

  // Read data and interrupt are both one cycle behind their sources.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dataOut <= 16'h0;
      r_irq     <= 1'b0;
    end else begin
      r_dataOut <= w_rdEn ? w_rdData : 16'h0;
      r_irq     <= |(r_pending & w_mask);
    end
  end

  assign data_out = r_dataOut;
  assign irq      = r_irq;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// ---------------------------------------------------------------------------
// tb_timer_alarm_sched
//
// Directed scenarios followed by a randomized bus phase. A tick-level
// reference model of the scheduler predicts data_out and irq every cycle.
// ---------------------------------------------------------------------------
module tb_timer_alarm_sched;

  localparam int PRESC = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  addr;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [15:0] d_in;
  logic [15:0] data_out;
  logic        irq;

  int vectors;
  int miscompares;

  timer_alarm_sched #(
    .PRESC(PRESC),
    .NCH  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .d_in    (d_in),
    .data_out(data_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tick counter plus, per channel, the edge number at
  // which a matched alarm gets serviced (match edge + 2 + channel index).
  logic [15:0] mCount;
  int          mPresc;
  logic        mRun;
  logic [3:0]  mEn;
  logic [3:0]  mPer;
  logic [3:0]  mPending;
  logic [3:0]  mMask;
  logic [15:0] mCmp    [4];
  logic [15:0] mTarget [4];
  int          mSvcAt  [4];
  logic [15:0] mData;
  logic        mIrq;
  int          cyc;

  function automatic logic [15:0] modelRead(input logic [3:0] a);
    if (a == 4'h0) return mCount;
    if (a == 4'h1) return {7'd0, mRun, mPer, mEn};
    if (a == 4'h2) return {12'd0, mPending};
`ifdef TIMER_ALARM_IRQ_MASK_EN
    if (a == 4'h3) return {12'd0, mMask};
`endif
    if (a >= 4'h4 && a <= 4'h7) return mCmp[a - 4'h4];
    return 16'h0;
  endfunction

  task automatic modelStep();
    logic       tick;
    logic       wrE;
    logic       oldRun;
    logic [3:0] svc;
    logic [3:0] newEn;
    cyc++;
    if (!rst) begin
      mCount = 0; mPresc = 0; mRun = 0; mEn = 0; mPer = 0; mPending = 0;
      mMask = 4'hF; mData = 0; mIrq = 0;
      for (int i = 0; i < 4; i++) begin
        mCmp[i] = 0; mTarget[i] = 0; mSvcAt[i] = -1;
      end
      return;
    end
    wrE    = cs && wr;
    oldRun = mRun;
    tick   = mRun && (mPresc == PRESC - 1);
    mData  = (cs && rd) ? modelRead(addr) : 16'h0;
    mIrq   = |(mPending & mMask);
    svc = 4'h0;
    for (int i = 0; i < 4; i++) if (mSvcAt[i] == cyc) svc[i] = 1'b1;
    if (wrE && addr == 4'h2) mPending = mPending & ~d_in[3:0];
    mPending = mPending | svc;
    newEn = mEn;
    for (int i = 0; i < 4; i++) begin
      if (svc[i]) begin
        mSvcAt[i] = -1;
        if (mPer[i]) mTarget[i] = mTarget[i] + mCmp[i];
        else newEn[i] = 1'b0;
      end
    end
    if (tick && !(wrE && addr == 4'h0)) begin
      for (int i = 0; i < 4; i++)
        if (mEn[i] && (mCount + 16'd1) == mTarget[i]) mSvcAt[i] = cyc + 2 + i;
    end
    if (wrE && addr == 4'h1) begin
      for (int i = 0; i < 4; i++)
        if (d_in[i] && !mEn[i]) mTarget[i] = mCount + mCmp[i];
      newEn = d_in[3:0];
      mPer  = d_in[7:4];
      mRun  = d_in[8];
    end
    for (int i = 0; i < 4; i++) if (!newEn[i]) mSvcAt[i] = -1;
    mEn = newEn;
    if (wrE && addr >= 4'h4 && addr <= 4'h7) mCmp[addr - 4'h4] = d_in;
`ifdef TIMER_ALARM_IRQ_MASK_EN
    if (wrE && addr == 4'h3) mMask = d_in[3:0];
`endif
    if (wrE && addr == 4'h0) mCount = 16'h0;
    else if (tick) mCount = mCount + 16'd1;
    if (oldRun) mPresc = (mPresc == PRESC - 1) ? 0 : mPresc + 1;
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (data_out === mData) else begin
      miscompares++;
      $error("[TB] FAIL %s data_out at edge %0d: observed %h expected %h", tag, cyc, data_out, mData);
    end
    vectors++;
    assert (irq === mIrq) else begin
      miscompares++;
      $error("[TB] FAIL %s irq at edge %0d: observed %b expected %b", tag, cyc, irq, mIrq);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input bit ok);
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed timeout expected event", tag);
    end
  endtask

  task automatic tickClk();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("cycle");
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tickClk();
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic w, input logic r,
                               input logic [15:0] d);
    addr = a; wr = w; rd = r; cs = w | r; d_in = d;
    tickClk();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  // Advance until the next edge is the tick on which channel ch matches.
  task automatic waitMatchTick(input int ch, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      if (mPresc == PRESC - 1 && (mCount + 16'd1) == mTarget[ch]) ok = 1'b1;
      else idle(1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ok;
    logic [15:0] armCount;
    logic [15:0] fireCnt;
    logic [15:0] simCmp;
    logic [3:0]  rAddr;
    logic [15:0] rData;
    logic        runBit;
    int          sel;

    cs = 0; rd = 0; wr = 0; addr = 0; d_in = 0; rst = 0;
    cyc = 0; vectors = 0; miscompares = 0;

    // Reset
    idle(3);
    checkValue("reset_data_out", data_out, 16'h0);
    checkValue("reset_irq", {15'd0, irq}, 16'h0);
    rst = 1;
    applyStimulus(4'h0, 0, 1, 0);
    checkValue("reset_count", data_out, 16'h0);

    // One-shot channel 0, CMP=10, armed at COUNT=0
    applyStimulus(4'h4, 1, 0, 16'd10);
    applyStimulus(4'h1, 1, 0, 16'h0101);
    idle(100);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("oneshot_status", data_out, 16'h0001);
    checkValue("oneshot_irq", {15'd0, irq}, 16'h1);
    applyStimulus(4'h1, 0, 1, 0);
    checkValue("oneshot_en_cleared", data_out, 16'h0100);
    applyStimulus(4'h2, 1, 0, 16'h0001);
    idle(170);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("oneshot_no_refire", data_out, 16'h0000);

    // Periodic channel 1, period 5
    applyStimulus(4'h5, 1, 0, 16'd5);
    armCount = mCount;
    applyStimulus(4'h1, 1, 0, 16'h0122);
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 80 && !ok; t++) begin
        applyStimulus(4'h2, 0, 1, 0);
        if (data_out[1] === 1'b1) ok = 1'b1;
      end
      checkFlag("periodic_fire", ok);
      applyStimulus(4'h0, 0, 1, 0);
      fireCnt = data_out;
      checkValue("periodic_fire_count", fireCnt, armCount + 16'(5 * (k + 1)));
      applyStimulus(4'h2, 1, 0, 16'h0002);
      checkValue("periodic_irq_hold", {15'd0, irq}, 16'h1);
      idle(1);
      checkValue("periodic_irq_drop", {15'd0, irq}, 16'h0);
    end
    applyStimulus(4'h1, 1, 0, 16'h0100);

    // Target wrap (CMP=0xFFFF) and CMP=0, then COUNT cleared to reach them
    applyStimulus(4'h6, 1, 0, 16'hFFFF);
    applyStimulus(4'h7, 1, 0, 16'h0000);
    armCount = mCount;
    applyStimulus(4'h1, 1, 0, 16'h010C);
    idle(40);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("cmp_zero_no_early_fire", data_out, 16'h0000);
    applyStimulus(4'h0, 1, 0, 16'h1234);
    idle((int'(armCount) + 2) * PRESC + 16);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("wrap_and_zero_fire", data_out, 16'h000C);
    applyStimulus(4'h1, 0, 1, 0);
    checkValue("wrap_en_cleared", data_out, 16'h0100);
    applyStimulus(4'h2, 1, 0, 16'h000C);

    // Channels 0 and 3 share a target; W1C of bit 0 on its set edge
    simCmp = 16'($urandom_range(3, 9));
    applyStimulus(4'h4, 1, 0, simCmp);
    applyStimulus(4'h7, 1, 0, simCmp);
    applyStimulus(4'h1, 1, 0, 16'h0109);
    waitMatchTick(0, ok);
    checkFlag("simultaneous_tick", ok);
    idle(2);
    applyStimulus(4'h2, 1, 0, 16'h0001);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("w1c_vs_set", data_out, 16'h0001);
    idle(3);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("simultaneous_both", data_out, 16'h0009);
    applyStimulus(4'h2, 1, 0, 16'h0009);

    // Reset while the FSM is mid-pass with a hit still outstanding
    applyStimulus(4'h4, 1, 0, 16'd4);
    applyStimulus(4'h5, 1, 0, 16'd4);
    applyStimulus(4'h1, 1, 0, 16'h0103);
    waitMatchTick(1, ok);
    checkFlag("reset_tick", ok);
    idle(3);
    rst = 0;
    idle(2);
    rst = 1;
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("reset_mid_status", data_out, 16'h0000);
    applyStimulus(4'h1, 0, 1, 0);
    checkValue("reset_mid_ctrl", data_out, 16'h0000);
    checkValue("reset_mid_irq", {15'd0, irq}, 16'h0);
    idle(30);
    applyStimulus(4'h0, 0, 1, 0);
    checkValue("reset_count_frozen", data_out, 16'h0000);
    applyStimulus(4'h5, 0, 1, 0);
    checkValue("reset_cmp_cleared", data_out, 16'h0000);

`ifdef TIMER_ALARM_IRQ_MASK_EN
    applyStimulus(4'h3, 1, 0, 16'h0001);
    applyStimulus(4'h6, 1, 0, 16'd3);
    applyStimulus(4'h1, 1, 0, 16'h0104);
    idle(50);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("mask_status", data_out, 16'h0004);
    checkValue("mask_irq_low", {15'd0, irq}, 16'h0);
    applyStimulus(4'h3, 1, 0, 16'h0004);
    idle(1);
    checkValue("mask_irq_high", {15'd0, irq}, 16'h1);
    applyStimulus(4'h3, 1, 0, 16'h000F);
`else
    applyStimulus(4'h3, 1, 0, 16'h0005);
    applyStimulus(4'h3, 0, 1, 0);
    checkValue("nomask_read", data_out, 16'h0000);
    applyStimulus(4'h6, 1, 0, 16'd3);
    applyStimulus(4'h1, 1, 0, 16'h0104);
    idle(50);
    applyStimulus(4'h2, 0, 1, 0);
    checkValue("nomask_status", data_out, 16'h0004);
    checkValue("nomask_irq", {15'd0, irq}, 16'h1);
`endif
    applyStimulus(4'h2, 1, 0, 16'h000F);
    applyStimulus(4'h1, 1, 0, 16'h0100);

    // Randomized bus traffic against the model
    for (int n = 0; n < 2500; n++) begin
      sel    = $urandom_range(0, 9);
      rAddr  = 4'($urandom_range(0, 15));
      rData  = 16'($urandom);
      runBit = ($urandom_range(0, 7) != 0);
      case (sel)
        0, 1, 2, 3: idle(1);
        4, 5:       applyStimulus(rAddr, 0, 1, 0);
        6:          applyStimulus(4'h4 + 4'($urandom_range(0, 3)), 1, 0,
                                  16'($urandom_range(1, 12)));
        7:          applyStimulus(4'h1, 1, 0, {7'd0, runBit, rData[7:0]});
        8:          applyStimulus(4'h2, 1, 0, {12'd0, rData[3:0]});
        default:    applyStimulus(rAddr, 1, 0, rData);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
